ctrl_pipe_stage: RTL and testbench
==================================

Name: ctrl_pipe_stage

Overview:
Registered, handshaked successor to the combinational Controller. Decodes RV32I instructions into the 16-bit control bundle, adds a 2-entry elastic buffer (main + skid), load-use hazard bubble insertion, illegal-opcode flagging and pipeline flush. Sits between fetch and execute in the pipelined core.

Parameters:
CTRL_W, 16, control bundle width; fixed layout below, other values illegal.
EN_HAZARD, 1, 1 = insert load-use bubbles; 0 = never stall for hazards.
ILLEGAL_TRAP, 1, 1 = assert out_illegal on unknown opcode; 0 = pass as zero-ctrl NOP with out_illegal=0.

Ports:
clk  in  1  clock.
rst_n  in  1  Asynchronous, active-low reset.
flush  in  1  Synchronous kill of all held instructions.
in_valid  in  1  Upstream instruction valid.
in_ready  out  1  Registered; equals !skid_valid.
in_instr  in  32  Little-endian RV32I word.
in_pc  in  32  PC of in_instr.
out_valid  out  1  Main register valid.
out_ready  in  1  Downstream accept.
out_instr  out  32  Held instruction.
out_pc  out  32  Held PC.
out_ctrl  out  CTRL_W  {EX_OP[15:11], EXEA[10], EXEB[9], LDEXT[8:6], MEMR[5], MEMW[4], REGW[3], M2R[2], BRA[1], JMP[0]}.
out_rd  out  5  instr[11:7].
out_illegal  out  1  Opcode not in ucode table.
hazard_stall  out  1  Combinational; a bubble is being inserted this cycle.

Behaviour:
- Reset (async, rst_n=0): main_valid=0, skid_valid=0, out_ctrl=0, out_instr=0, out_pc=0, out_rd=0, out_illegal=0. in_ready=1 during and after reset.
- Decode is combinational at entry; ctrl is registered with the instruction. Latency: input accepted in cycle N appears on out_* in N+1 when no stall.
- candidate = skid if skid_valid, else input (when in_valid).
- can_load = !main_valid | out_ready.
- hazard = EN_HAZARD & main_valid & out_ctrl.MEMR & out_rd!=0 & candidate uses out_rd. rs1 used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 used by OP, STORE, BRANCH. LUI, AUIPC, JAL use neither.
- Main loads candidate when can_load & !hazard & candidate present.
- If can_load & hazard: main_valid<=0 next cycle (one bubble); candidate held. hazard_stall = can_load & hazard.
- Input handshake fires on in_valid & in_ready. If main is not loading from the input this cycle, input goes into skid (skid_valid<=1).
- Skid drains into main with priority over the input. in_ready stays 0 while skid_valid=1.
- Simultaneous skid drain and input handshake cannot occur: in_ready=0 whenever skid is full.
- Unknown opcode:
  - ILLEGAL_TRAP=1: ctrl=0, out_illegal=1.
  - ILLEGAL_TRAP=0: ctrl=0, out_illegal=0.
  - Either way it is never a hazard producer (MEMR=0).
- flush=1: main_valid<=0 and skid_valid<=0 next cycle; any same-cycle input handshake is discarded. Flush overrides hazard and load. hazard_stall is still driven combinationally.
- rd=x0 loads never cause hazards. Back-to-back loads chain correctly: each dependent instruction gets exactly one bubble.
- out_* payload holds its value while out_valid & !out_ready.

Decomposition:
- Shared package/header (extends types.vh):
  - opcode constants.
  - ctrl bundle field offsets.
  - the ucode.vh INSTR table (single source for RTL and bench gold vectors).
  - ENDIAN_SWP_32.
- One sub-module: ctrl_decode. Purely combinational: instr -> ctrl, illegal, uses_rs1, uses_rs2. Generated from ucode.vh.

Test Plan:
- Decode sweep: all 40 vectors from controller.mem with out_ready=1 -> each out_ctrl equals the ucode gold one cycle after acceptance; out_illegal=0.
- Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333), out_ready=1 -> one cycle with out_valid=0 and hazard_stall=1, then the add appears. Repeat with EN_HAZARD=0 -> no gap.
- No false hazard: lw x0,0(x1) (0x0000A003) then add x6,x0,x2 (0x00200333) -> no bubble. lw x5 then lui x5,1 (0x000012B7) -> no bubble.
- Backpressure: stream of addi x1,x0,1 (0x00100093); hold out_ready=0 for 3 cycles.
  - Skid fills; in_ready=0 from the second cycle.
  - Release -> all instructions delivered in order, no loss or duplication.
- Flush: main and skid both full; assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output.
- Illegal/reset:
  - 0xFFFFFFFF -> out_ctrl=0, out_illegal=1 (0 with ILLEGAL_TRAP=0).
  - Drop rst_n mid-stream -> out_valid=0 immediately (async), in_ready=1.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the registered control stage:
// opcodes, ctrl bundle layout and the ucode gold table.
package ctrl_pipe_pkg;

  localparam int CTRL_WIDTH = 16;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int B_JMP   = 0;
  localparam int B_BRA   = 1;
  localparam int B_M2R   = 2;
  localparam int B_REGW  = 3;
  localparam int B_MEMW  = 4;
  localparam int B_MEMR  = 5;
  localparam int B_LDEXT = 6;
  localparam int B_EXEB  = 9;
  localparam int B_EXEA  = 10;
  localparam int B_EXOP  = 11;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_BEQ,
    ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU
  } alu_op_e;

  typedef struct packed {
    alu_op_e    ex_op;
    logic       exea;
    logic       exeb;
    logic [2:0] ldext;
    logic       memr;
    logic       memw;
    logic       regw;
    logic       m2r;
    logic       bra;
    logic       jmp;
  } ctrl_t;

  localparam int UCODE_N = 40;

  localparam logic [47:0] UCODE [UCODE_N] = '{
    {32'h000012B7, 16'h5208}, {32'h00001297, 16'h0608},
    {32'h000000EF, 16'h0609}, {32'h000100E7, 16'h0209},
    {32'h00208063, 16'h5802}, {32'h00209063, 16'h6002},
    {32'h0020C063, 16'h6802}, {32'h0020D063, 16'h7002},
    {32'h0020E063, 16'h7802}, {32'h0020F063, 16'h8002},
    {32'h00008283, 16'h022C}, {32'h00009283, 16'h026C},
    {32'h0000A283, 16'h02AC}, {32'h0000C283, 16'h032C},
    {32'h0000D283, 16'h036C}, {32'h00208023, 16'h0210},
    {32'h00209023, 16'h0210}, {32'h0020A023, 16'h0210},
    {32'h00110093, 16'h0208}, {32'h00112093, 16'h1A08},
    {32'h00113093, 16'h2208}, {32'h00114093, 16'h2A08},
    {32'h00116093, 16'h4208}, {32'h00117093, 16'h4A08},
    {32'h00111093, 16'h1208}, {32'h00115093, 16'h3208},
    {32'h40115093, 16'h3A08}, {32'h00228333, 16'h0008},
    {32'h40228333, 16'h0808}, {32'h00229333, 16'h1008},
    {32'h0022A333, 16'h1808}, {32'h0022B333, 16'h2008},
    {32'h0022C333, 16'h2808}, {32'h0022D333, 16'h3008},
    {32'h4022D333, 16'h3808}, {32'h0022E333, 16'h4008},
    {32'h0022F333, 16'h4808}, {32'h0FF0000F, 16'h0000},
    {32'h00000073, 16'h0000}, {32'h00100073, 16'h0000}
  };

  function automatic logic [31:0] endian_swp_32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_decode.sv
// RV32I opcode decoder: instr to ctrl bundle,
// illegal flag and source-register usage.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  alu_op_e    alu_op;
  alu_op_e    br_op;
  logic       is_lui, is_auipc, is_jal, is_jalr;
  logic       is_br, is_load, is_store;
  logic       is_opimm, is_op, is_fence, is_sys;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign alt      = instr[30];
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_load  = opc == OPC_LOAD;
  assign is_store = opc == OPC_STORE;
  assign is_opimm = opc == OPC_OPIMM;
  assign is_op    = opc == OPC_OP;
  assign is_fence = opc == OPC_FENCE;
  assign is_sys   = opc == OPC_SYSTEM;

  // funct3 picks the ALU op; bit 30 picks SUB (reg-reg only) and SRA
  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      3'd0:    alu_op = (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  // branch compare selection
  always_comb begin
    br_op = ALU_BEQ;
    case (f3)
      3'd1:    br_op = ALU_BNE;
      3'd4:    br_op = ALU_BLT;
      3'd5:    br_op = ALU_BGE;
      3'd6:    br_op = ALU_BLTU;
      3'd7:    br_op = ALU_BGEU;
      default: br_op = ALU_BEQ;
    endcase
  end

  // opcode class to control bundle
  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      is_lui: begin
        ctrl.ex_op = ALU_LUI;
        ctrl.exeb  = 1'b1;
        ctrl.regw  = 1'b1;
      end
      is_auipc: begin
        ctrl.exea = 1'b1;
        ctrl.exeb = 1'b1;
        ctrl.regw = 1'b1;
      end
      is_jal: begin
        ctrl.exea = 1'b1;
        ctrl.exeb = 1'b1;
        ctrl.regw = 1'b1;
        ctrl.jmp  = 1'b1;
      end
      is_jalr: begin
        ctrl.exeb = 1'b1;
        ctrl.regw = 1'b1;
        ctrl.jmp  = 1'b1;
        uses_rs1  = 1'b1;
      end
      is_br: begin
        ctrl.ex_op = br_op;
        ctrl.bra   = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      is_load: begin
        ctrl.exeb  = 1'b1;
        ctrl.ldext = f3;
        ctrl.memr  = 1'b1;
        ctrl.regw  = 1'b1;
        ctrl.m2r   = 1'b1;
        uses_rs1   = 1'b1;
      end
      is_store: begin
        ctrl.exeb = 1'b1;
        ctrl.memw = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      is_opimm: begin
        ctrl.ex_op = alu_op;
        ctrl.exeb  = 1'b1;
        ctrl.regw  = 1'b1;
        uses_rs1   = 1'b1;
      end
      is_op: begin
        ctrl.ex_op = alu_op;
        ctrl.regw  = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      is_fence, is_sys: ;
      default: illegal = ILLEGAL_TRAP;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Registered decode stage with skid buffer,
// load-use bubble insertion and flush.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W       = 16,
  parameter bit EN_HAZARD    = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic              hazard_stall
);

  logic        main_valid, main_ill;
  logic [31:0] main_instr, main_pc;
  ctrl_t       main_ctrl;
  logic        skid_valid;
  logic [31:0] skid_instr, skid_pc;
  logic [31:0] cand_instr, cand_pc;
  logic        cand_present, can_load;
  logic        rs_hit, hazard, load_main, in_fire;
  logic [4:0]  main_rd;
  ctrl_t       dec_ctrl;
  logic        dec_ill, dec_rs1, dec_rs2;

  ctrl_decode #(
    .ILLEGAL_TRAP(ILLEGAL_TRAP)
  ) u_dec (
    .instr   (cand_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill),
    .uses_rs1(dec_rs1),
    .uses_rs2(dec_rs2)
  );

  assign in_ready     = !skid_valid;
  assign in_fire      = in_valid && in_ready;
  assign cand_instr   = skid_valid ? skid_instr : in_instr;
  assign cand_pc      = skid_valid ? skid_pc : in_pc;
  assign cand_present = skid_valid || in_valid;
  assign can_load     = !main_valid || out_ready;
  assign main_rd      = main_instr[11:7];

  assign rs_hit =
    (dec_rs1 && cand_instr[19:15] == main_rd) ||
    (dec_rs2 && cand_instr[24:20] == main_rd);

  assign hazard = EN_HAZARD && main_valid &&
    main_ctrl.memr && main_rd != 5'd0 &&
    cand_present && rs_hit;

  assign hazard_stall = can_load && hazard;
  assign load_main    = can_load && !hazard &&
    cand_present && !flush;

  assign out_valid   = main_valid;
  assign out_instr   = main_instr;
  assign out_pc      = main_pc;
  assign out_ctrl    = main_ctrl;
  assign out_rd      = main_rd;
  assign out_illegal = main_ill;

  // main register: load candidate, bubble on hazard, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_instr <= '0;
      main_pc    <= '0;
      main_ctrl  <= '0;
      main_ill   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (load_main) begin
      main_valid <= 1'b1;
      main_instr <= cand_instr;
      main_pc    <= cand_pc;
      main_ctrl  <= dec_ctrl;
      main_ill   <= dec_ill;
    end else if (can_load) begin
      main_valid <= 1'b0;
    end
  end

  // skid: catch an accepted input main could not take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (load_main) skid_valid <= 1'b0;
    end else if (in_fire && !load_main) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: directed cases plus
// a random scoreboard run on the default build.
module tb_ctrl_pipe_stage;
  import ctrl_pipe_pkg::*;

  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD0 = 32'h00200333;
  localparam logic [31:0] LUI5 = 32'h000012B7;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW6  = 32'h0002A303;
  localparam logic [31:0] ADD7 = 32'h002303B3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic        ill;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        o0_in_ready, o0_out_valid;
  logic [31:0] o0_out_instr, o0_out_pc;
  logic [15:0] o0_out_ctrl;
  logic [4:0]  o0_out_rd;
  logic        o0_out_illegal, o0_stall;
  logic        o1_in_ready, o1_out_valid;
  logic [31:0] o1_out_instr, o1_out_pc;
  logic [15:0] o1_out_ctrl;
  logic [4:0]  o1_out_rd;
  logic        o1_out_illegal, o1_stall;

  int n_chk = 0;
  int n_err = 0;

  ctrl_pipe_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_instr(o0_out_instr), .out_pc(o0_out_pc),
    .out_ctrl(o0_out_ctrl), .out_rd(o0_out_rd),
    .out_illegal(o0_out_illegal),
    .hazard_stall(o0_stall)
  );

  ctrl_pipe_stage #(
    .EN_HAZARD(1'b0), .ILLEGAL_TRAP(1'b0)
  ) u_nh (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_instr(o1_out_instr), .out_pc(o1_out_pc),
    .out_ctrl(o1_out_ctrl), .out_rd(o1_out_rd),
    .out_illegal(o1_out_illegal),
    .hazard_stall(o1_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, return at the negedge
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic rdy,
                      input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic use1(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic use2(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h23, 7'h63: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [47:0] ent;
    logic [31:0] w;
    logic [31:0] dins [3];
    int          dcyc [3];
    logic [31:0] chain [3];
    int          sent, got, k, cyc_n, l_cyc;
    logic        pend, lv, l_load;
    logic [4:0]  l_rd;
    item_t       q [$];
    item_t       cur, it;
    logic [31:0] pcs [$];

    // reset values
    @(negedge clk);
    chk("rst_valid", o0_out_valid, 0);
    chk("rst_ready", o0_in_ready, 1);
    chk("rst_ctrl", o0_out_ctrl, 0);
    chk("rst_instr", o0_out_instr, 0);
    chk("rst_pc", o0_out_pc, 0);
    chk("rst_rd", o0_out_rd, 0);
    chk("rst_ill", o0_out_illegal, 0);
    chk("rst_ready_nh", o1_in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // decode sweep, one cycle latency
    for (int i = 0; i <= UCODE_N; i++) begin
      if (i < UCODE_N) begin
        ent = UCODE[i];
        step(1'b1, ent[47:16], 32'(i * 4), 1'b1, 1'b0);
      end else begin
        step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      if (i > 0) begin
        ent = UCODE[i-1];
        chk("dec_valid", o0_out_valid, 1);
        chk("dec_instr", o0_out_instr, ent[47:16]);
        chk("dec_ctrl", o0_out_ctrl, ent[15:0]);
        chk("dec_ill", o0_out_illegal, 0);
        chk("dec_ctrl_nh", o1_out_ctrl, ent[15:0]);
      end
    end
    idle(2);

    // load-use bubble vs no-hazard build
    step(1'b1, LW5, 32'h200, 1'b1, 1'b0);
    step(1'b1, ADD6, 32'h204, 1'b1, 1'b0);
    chk("lu_lw", o0_out_instr, LW5);
    chk("lu_stall", o0_stall, 1);
    chk("lu_stall_nh", o1_stall, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lu_bubble", o0_out_valid, 0);
    chk("lu_nh_valid", o1_out_valid, 1);
    chk("lu_nh_add", o1_out_instr, ADD6);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lu_add_valid", o0_out_valid, 1);
    chk("lu_add", o0_out_instr, ADD6);
    idle(2);

    // no false hazards: rd=x0 load, and LUI reading nothing
    step(1'b1, LW0, 32'h300, 1'b1, 1'b0);
    step(1'b1, ADD0, 32'h304, 1'b1, 1'b0);
    chk("x0_stall", o0_stall, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("x0_valid", o0_out_valid, 1);
    chk("x0_add", o0_out_instr, ADD0);
    step(1'b1, LW5, 32'h308, 1'b1, 1'b0);
    step(1'b1, LUI5, 32'h30C, 1'b1, 1'b0);
    chk("lui_stall", o0_stall, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lui_valid", o0_out_valid, 1);
    chk("lui_out", o0_out_instr, LUI5);
    idle(2);

    // chained loads: one bubble per dependent
    chain[0] = LW5;
    chain[1] = LW6;
    chain[2] = ADD7;
    sent = 0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      step(sent < 3, (sent < 3) ? chain[sent] : '0,
           32'(sent * 4), 1'b1, 1'b0);
      if (o0_out_valid && got < 3) begin
        dins[got] = o0_out_instr;
        dcyc[got] = c;
        got++;
      end
      if (in_valid && o0_in_ready) sent++;
    end
    chk("ch_count", got, 3);
    for (int i = 0; i < 3; i++) chk("ch_order", dins[i], chain[i]);
    chk("ch_gap1", dcyc[1] - dcyc[0], 2);
    chk("ch_gap2", dcyc[2] - dcyc[1], 2);
    idle(2);

    // backpressure: out_ready low for three cycles
    sent = 0;
    pcs.delete();
    for (int c = 0; c < 30; c++) begin
      step(sent < 6, ADDI, 32'h100 + 32'(sent * 4),
           c >= 3, 1'b0);
      if (c == 1) chk("bp_ready1", o0_in_ready, 1);
      if (c == 2) chk("bp_ready2", o0_in_ready, 0);
      if (o0_out_valid && out_ready) pcs.push_back(o0_out_pc);
      if (in_valid && o0_in_ready) sent++;
    end
    chk("bp_count", pcs.size(), 6);
    for (int i = 0; i < pcs.size(); i++)
      chk("bp_order", pcs[i], 32'h100 + 32'(i * 4));
    idle(2);

    // flush with main and skid full
    step(1'b1, ADDI, 32'hA0, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'hA4, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'hDEAD0000, 1'b0, 1'b1);
    chk("fl_full_v", o0_out_valid, 1);
    chk("fl_full_r", o0_in_ready, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("fl_valid", o0_out_valid, 0);
    chk("fl_ready", o0_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("fl_quiet", o0_out_valid, 0);
    end
    // flush discarding a same-cycle handshake
    step(1'b1, ADDI, 32'hB0, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'hBEEF0000, 1'b0, 1'b1);
    chk("fl2_ready", o0_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("fl2_quiet", o0_out_valid, 0);
    end

    // illegal opcode on both builds
    step(1'b1, 32'hFFFFFFFF, 32'hC0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("ill_valid", o0_out_valid, 1);
    chk("ill_ctrl", o0_out_ctrl, 0);
    chk("ill_flag", o0_out_illegal, 1);
    chk("ill_ctrl_nh", o1_out_ctrl, 0);
    chk("ill_flag_nh", o1_out_illegal, 0);
    idle(2);

    // random stream against an in-order scoreboard
    pend = 1'b0;
    lv = 1'b0;
    l_load = 1'b0;
    l_rd = '0;
    l_cyc = 0;
    cyc_n = 0;
    cur = '{default: '0};
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      if (!pend) begin
        in_valid = $urandom_range(0, 9) < 7;
        k = $urandom_range(0, UCODE_N);
        if (k == UCODE_N) begin
          w = $urandom;
          w[6:0] = 7'h7F;
          cur.ctrl = '0;
          cur.ill = 1'b1;
        end else begin
          ent = UCODE[k];
          w = ent[47:16];
          w[11:7] = 5'($urandom_range(0, 3));
          w[19:15] = 5'($urandom_range(0, 3));
          w[24:20] = 5'($urandom_range(0, 3));
          cur.ctrl = ent[15:0];
          cur.ill = 1'b0;
        end
        cur.instr = w;
        cur.pc = $urandom;
        in_instr = cur.instr;
        in_pc = cur.pc;
      end
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 49) == 0;
      @(negedge clk);
      cyc_n++;
      if (o0_out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", o0_out_pc, 0);
        end else begin
          it = q.pop_front();
          chk("rnd_instr", o0_out_instr, it.instr);
          chk("rnd_pc", o0_out_pc, it.pc);
          chk("rnd_ctrl", o0_out_ctrl, it.ctrl);
          chk("rnd_ill", o0_out_illegal, it.ill);
          if (lv && l_load && l_rd != 0 &&
              ((use1(it.instr) && it.instr[19:15] == l_rd) ||
               (use2(it.instr) && it.instr[24:20] == l_rd)))
            chk("rnd_bubble", cyc_n - l_cyc >= 2, 1);
          lv = 1'b1;
          l_load = it.instr[6:0] == 7'h03;
          l_rd = it.instr[11:7];
          l_cyc = cyc_n;
        end
      end
      if (flush) begin
        q.delete();
        lv = 1'b0;
        pend = 1'b0;
      end else if (in_valid && o0_in_ready) begin
        q.push_back(cur);
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      if (o0_out_valid) begin
        if (q.size() == 0) begin
          chk("drn_spurious", o0_out_pc, 0);
        end else begin
          it = q.pop_front();
          chk("drn_instr", o0_out_instr, it.instr);
          chk("drn_pc", o0_out_pc, it.pc);
        end
      end
    end
    chk("drn_empty", q.size(), 0);

    // asynchronous reset mid-stream
    step(1'b1, ADDI, 32'hE0, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'hE4, 1'b0, 1'b0);
    chk("ar_pre", o0_out_valid, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ar_valid", o0_out_valid, 0);
    chk("ar_ready", o0_in_ready, 1);
    chk("ar_instr", o0_out_instr, 0);
    chk("ar_ready_nh", o1_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_after", o0_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
